// File: rtl/spm_prog_loader_pkg.sv
// Shared definitions for the SPM program loader: FSM states and SPM test-port
// strobe/direction encodings.
package spm_prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        VRD,
        VWAIT,
        CMP,
        DONE
    } state_t;

    localparam logic SPM_RW_WRITE   = 1'b1;
    localparam logic SPM_RW_READ    = 1'b0;
    localparam logic SPM_AS_ENABLE  = 1'b0;
    localparam logic SPM_AS_DISABLE = 1'b1;

endpackage

// File: rtl/spm_prog_loader_rd_pipe.sv
// Read-latency tracker: a tag enters with each read strobe and emerges RD_LAT
// cycles later, marking the cycle in which spm_rd_data holds that read's word.
module spm_rd_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic flush,
    input  logic rd_issue,
    output logic rd_capture
);

    logic [RD_LAT-1:0] tag;

    always_ff @(posedge clk) begin
        if (flush) begin
            tag <= '0;
        end else begin
            tag <= RD_LAT'({tag, rd_issue});
        end
    end

    assign rd_capture = tag[RD_LAT-1];

endmodule

// File: rtl/spm_prog_loader.sv
// Streams an instruction image from a valid/ready source into the SPM test
// port, optionally verifies it by readback checksum, then enables the CPU.
module spm_prog_loader
    import spm_prog_loader_pkg::*;
#(
    parameter int unsigned AW     = 30,
    parameter int unsigned DW     = 32,
    parameter int unsigned CW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_cnt,
    input  logic          verify_en,
    input  logic          auto_run,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [AW-1:0] spm_addr,
    output logic          spm_as_,
    output logic          spm_rw,
    output logic [DW-1:0] spm_wr_data,
    input  logic [DW-1:0] spm_rd_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] checksum,
    output logic          cpu_en
);

    state_t        state;
    logic [AW-1:0] base_q;
    logic [CW-1:0] cnt_q;
    logic          verify_q;
    logic          auto_q;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] rd_idx;
    logic [CW-1:0] cap_idx;
    logic [DW-1:0] vsum;
    logic          rd_issue;
    logic          rd_capture;

    assign in_ready = (state == WRITE);
    // The read strobe currently on the bus is what starts the latency count.
    assign rd_issue = (spm_as_ == SPM_AS_ENABLE) && (spm_rw == SPM_RW_READ);

    spm_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk        (clk),
        .flush      (reset | abort),
        .rd_issue   (rd_issue),
        .rd_capture (rd_capture)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            spm_as_     <= SPM_AS_DISABLE;
            spm_rw      <= SPM_RW_READ;
            spm_addr    <= '0;
            spm_wr_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            checksum    <= '0;
            cpu_en      <= 1'b0;
            base_q      <= '0;
            cnt_q       <= '0;
            verify_q    <= 1'b0;
            auto_q      <= 1'b0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            cap_idx     <= '0;
            vsum        <= '0;
        end else if (abort) begin
            state   <= IDLE;
            spm_as_ <= SPM_AS_DISABLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cpu_en  <= 1'b0;
        end else begin
            spm_as_ <= SPM_AS_DISABLE;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        cnt_q    <= word_cnt;
                        verify_q <= verify_en;
                        auto_q   <= auto_run;
                        error    <= 1'b0;
                        checksum <= '0;
                        wr_idx   <= '0;
                        rd_idx   <= '0;
                        cap_idx  <= '0;
                        vsum     <= '0;
                        if (word_cnt == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            cpu_en <= auto_run;
                        end else begin
                            state  <= WRITE;
                            busy   <= 1'b1;
                            cpu_en <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (in_valid) begin
                        spm_as_     <= SPM_AS_ENABLE;
                        spm_rw      <= SPM_RW_WRITE;
                        spm_addr    <= base_q + AW'(wr_idx);
                        spm_wr_data <= in_data;
                        checksum    <= checksum + in_data;
                        wr_idx      <= wr_idx + CW'(1);
                        if (wr_idx == cnt_q - CW'(1)) begin
                            if (verify_q) begin
                                state <= VRD;
                            end else begin
                                state  <= DONE;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                cpu_en <= auto_q;
                            end
                        end
                    end
                end
                VRD: begin
                    spm_as_  <= SPM_AS_ENABLE;
                    spm_rw   <= SPM_RW_READ;
                    spm_addr <= base_q + AW'(rd_idx);
                    rd_idx   <= rd_idx + CW'(1);
                    if (rd_idx == cnt_q - CW'(1)) begin
                        state <= VWAIT;
                    end
                    if (rd_capture) begin
                        vsum    <= vsum + spm_rd_data;
                        cap_idx <= cap_idx + CW'(1);
                    end
                end
                VWAIT: begin
                    // The last read can only return here, never while still in VRD.
                    if (rd_capture) begin
                        vsum    <= vsum + spm_rd_data;
                        cap_idx <= cap_idx + CW'(1);
                        if (cap_idx == cnt_q - CW'(1)) begin
                            state <= CMP;
                        end
                    end
                end
                CMP: begin
                    if (vsum == checksum) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cpu_en <= auto_q;
                    end else begin
                        state <= IDLE;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
